// File: rtl/game_state_ctrl.sv
// Frame-rate game controller: IDLE/RUNNING/DEAD sequencing, scroll step and BCD score.
// Define GAME_HISCORE_EN to build the high-score register, BCD comparator and newHigh pulse.
//
// state   | meaning
// IDLE    | waiting for the first button rise, nothing scrolls
// RUNNING | scrolling, score and speed ramp advancing
// DEAD    | frozen after a collision, restart allowed once the hold time has elapsed
module game_state_ctrl #(
  parameter int DX_INIT           = 6,
  parameter int DX_MAX            = 20,
  parameter int SPEED_STEP_FRAMES = 600,
  parameter int SCORE_DIV         = 6,
  parameter int DEAD_HOLD_FRAMES  = 60
) (
  input  logic        FrameClk,
  input  logic        rst,
  input  logic        jumpBtn,
  input  logic        collision,
  output logic [1:0]  gameState,
  output logic [7:0]  scrollDx,
  output logic [15:0] score,
  output logic [15:0] hiScore,
  output logic        newHigh
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    DEAD    = 2'b10
  } gameStateT;

  if (DX_MAX >= 256 || DX_MAX < 0 || DX_INIT < 0 || DX_INIT > DX_MAX ||
      SPEED_STEP_FRAMES < 1 || SCORE_DIV < 1 || DEAD_HOLD_FRAMES < 1) begin : gBadParams
    $error("game_state_ctrl: illegal parameter set");
  end

  localparam logic [7:0]  DX_INIT_C   = 8'(DX_INIT);
  localparam logic [7:0]  DX_MAX_C    = 8'(DX_MAX);
  localparam logic [15:0] SCORE_LAST  = 16'(SCORE_DIV - 1);
  localparam logic [15:0] SPEED_LAST  = 16'(SPEED_STEP_FRAMES - 1);
  localparam logic [15:0] HOLD_C      = 16'(DEAD_HOLD_FRAMES);
  localparam logic [15:0] SCORE_SAT   = 16'h9999;

  gameStateT   state;
  logic        btnPrev;
  logic        btnRise;
  logic [15:0] scoreDiv;
  logic [15:0] speedCnt;
  logic [15:0] holdCnt;

  assign btnRise   = jumpBtn & ~btnPrev;
  assign gameState = state;

  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge FrameClk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      scrollDx <= '0;
      score    <= '0;
      btnPrev  <= 1'b0;
      scoreDiv <= '0;
      speedCnt <= '0;
      holdCnt  <= '0;
    end else begin
      btnPrev <= jumpBtn;
      case (state)
        IDLE: begin
          if (btnRise) begin
            state    <= RUNNING;
            score    <= '0;
            scrollDx <= DX_INIT_C;
            scoreDiv <= '0;
            speedCnt <= '0;
          end
        end
        RUNNING: begin
          if (collision) begin
            state    <= DEAD;
            scrollDx <= '0;
            holdCnt  <= '0;
          end else begin
            if (scoreDiv == SCORE_LAST) begin
              scoreDiv <= '0;
              if (score != SCORE_SAT) score <= bcdInc(score);
            end else begin
              scoreDiv <= scoreDiv + 16'd1;
            end
            if (speedCnt == SPEED_LAST) begin
              speedCnt <= '0;
              if (scrollDx < DX_MAX_C) scrollDx <= scrollDx + 8'd1;
            end else begin
              speedCnt <= speedCnt + 16'd1;
            end
          end
        end
        DEAD: begin
          scrollDx <= '0;
          // compare uses the pre-edge hold count, so a rise on the edge that saturates it is ignored
          if (btnRise && holdCnt == HOLD_C) begin
            state    <= RUNNING;
            score    <= '0;
            scrollDx <= DX_INIT_C;
            scoreDiv <= '0;
            speedCnt <= '0;
          end else if (holdCnt < HOLD_C) begin
            holdCnt <= holdCnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          scrollDx <= '0;
        end
      endcase
    end
  end

`ifdef GAME_HISCORE_EN
  // valid packed BCD orders the same as its binary value, so a plain magnitude compare is digit-wise from the MSD
  always_ff @(posedge FrameClk or negedge rst) begin
    if (!rst) begin
      hiScore <= '0;
      newHigh <= 1'b0;
    end else begin
      newHigh <= 1'b0;
      if (state == RUNNING && collision && score > hiScore) begin
        hiScore <= score;
        newHigh <= 1'b1;
      end
    end
  end
`else
  assign hiScore = 16'h0000;
  assign newHigh = 1'b0;
`endif

endmodule
